// File: rtl/seg_capture_pkg.sv
// seg_capture_pkg: shared segment patterns, FSM encoding and default frame width
// for the seven-segment frame capture block.
package seg_capture_pkg;

    localparam int DEFAULT_NUM_DIGITS = 6;

    // Active-low patterns, bit0=a .. bit6=g, indexed by the hex value they show
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {COLLECT, HOLD} state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: combinational decode of an active-low segment pattern to a hex
// nibble, flagging patterns outside the table (nibble forced to 0).
module seg7_to_hex
    import seg_capture_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_invalid
);

    always_comb begin
        o_nibble  = '0;
        o_invalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SEG_TABLE[i]) begin
                o_nibble  = 4'(i);
                o_invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: gathers strobed seven-segment digits into a decoded frame and
// holds it for a valid/ready consumer; strobes lost while holding raise overrun.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [2:0]              digit_sel,
    input  logic                    seg_strobe,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [NUM_DIGITS-1:0]   out_error,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    state_t                  r_state;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_error;
    logic                    r_valid;
    logic                    r_overrun;

    logic [3:0]              w_nibble;
    logic                    w_invalid;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_next_mask;
    logic                    w_xfer;
    logic                    w_open;
    logic                    w_accept;

    seg7_to_hex u_dec (
        .i_seg     (seg_in),
        .o_nibble  (w_nibble),
        .o_invalid (w_invalid)
    );

    // Out-of-range digit_sel yields an all-zero w_sel, so it is silently ignored
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            w_sel[i] = seg_strobe && (digit_sel == 3'(i));
    end

    assign w_xfer      = (r_state == HOLD) && r_valid && out_ready;
    assign w_open      = (r_state == COLLECT) || w_xfer;
    assign w_accept    = w_open && |w_sel;
    assign w_next_mask = (w_xfer ? '0 : r_mask) | (w_accept ? w_sel : '0);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= COLLECT;
            r_mask    <= '0;
            r_value   <= '0;
            r_error   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_accept && w_sel[i]) begin
                    r_value[4*i +: 4] <= w_nibble;
                    r_error[i]        <= w_invalid;
                end
            end
            if (w_open) begin
                r_mask  <= w_next_mask;
                r_state <= &w_next_mask ? HOLD : COLLECT;
                r_valid <= &w_next_mask;
            end
            if (!w_open && |w_sel)
                r_overrun <= 1'b1;
        end
    end

    assign out_value = r_value;
    assign out_error = r_error;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, the number of digits per frame (1-8).
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port seg_in, input, 7 bits: active-low segment pattern, bit0=a through bit6=g.
REQ-005 SHALL have port digit_sel, input, 3 bits: index of the digit currently presented on seg_in.
REQ-006 SHALL have port seg_strobe, input, 1 bit: seg_in and digit_sel are valid this cycle.
REQ-007 SHALL have port out_value, output, 4*NUM_DIGITS bits: decoded frame; digit i occupies bits [4i+3:4i].
REQ-008 SHALL have port out_error, output, NUM_DIGITS bits: bit i set means digit i carried a pattern not in the decode table.
REQ-009 SHALL have port out_valid, output, 1 bit: frame available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the frame.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, a strobe was dropped.

Function
REQ-012 SHALL decode active-low patterns as 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh.
REQ-013 SHALL store nibble 0 and set the digit's error bit for any other pattern.
REQ-014 SHALL implement states COLLECT and HOLD; reset enters COLLECT.
REQ-015 In COLLECT, a strobe with digit_sel<NUM_DIGITS SHALL write that digit's nibble and error bit at the sampling edge and set its capture-mask bit.
REQ-016 A strobe with digit_sel>=NUM_DIGITS SHALL be ignored, with no flag raised.
REQ-017 A repeated digit within one frame SHALL overwrite the earlier nibble and error bit.
REQ-018 When the capture mask becomes all ones, the block SHALL enter HOLD, with out_valid high from the next cycle (latency 1 cycle from the completing strobe).
REQ-019 In HOLD, out_value and out_error SHALL stay stable until the edge at which out_valid and out_ready are both high.
REQ-020 At that transfer edge the block SHALL return to COLLECT, clear the mask, and drop out_valid in the following cycle.
REQ-021 A strobe coincident with the transfer edge SHALL be captured as the first digit of the new frame.
REQ-022 Any other strobe in HOLD SHALL be dropped and set overrun; overrun clears only on reset.
REQ-023 out_ready while in COLLECT SHALL have no effect.
REQ-024 out_valid SHALL never assert combinationally from inputs.

Reset
REQ-025 Asserting reset at any time, including mid-frame or in HOLD, SHALL force COLLECT, mask=0, out_value=0, out_error=0, out_valid=0, overrun=0.
REQ-026 Strobes SHALL be honoured from the first rising edge after reset deasserts.

Structure
REQ-027 A shared package SHALL hold the 16 segment-pattern constants, the state encoding, and the default NUM_DIGITS.
REQ-028 Decoding SHALL sit in one combinational sub-module, seg7_to_hex (7-bit pattern in; 4-bit nibble and invalid flag out), instantiated once.

Verification
REQ-029 Strobe digits 0-5 with patterns 40h, 79h, 24h, 30h, 19h, 12h, out_ready=1 -> out_valid for exactly one cycle, one cycle after the 6th strobe; out_value=543210h, out_error=0.
REQ-030 Frame with digit 2 = 7Fh -> nibble 2 = 0, out_error=000100b, other digits correct.
REQ-031 Complete frame with out_ready=0 for 5 cycles, strobing digit 0 each cycle -> out_value unchanged, overrun=1, frame delivered on the first cycle out_ready rises.
REQ-032 Strobe coincident with the transfer edge (digit 3, pattern 08h) -> that nibble = Ah in the next frame; overrun stays 0.
REQ-033 Digit 1 sent twice (79h then 0Eh) and digit_sel=7 strobed once -> nibble 1 = Fh, frame completes only after all six valid indices.
REQ-034 Reset pulsed after 3 digits, and again in HOLD -> all outputs 0; the next frame requires all six digits.
